atm_multi_account: RTL
======================

// Module: atm_multi_account
// PURPOSE
//  Multi-account successor to the single-account ATM FSM. It serves NUM_ACCOUNTS
//  accounts, each with its own PIN and a running balance that is debited on every
//  dispense. Wrong-PIN lockout, an idle timeout and an error code are added.
//  Sits between the front-panel inputs (card/pin/amount/next/cancel) and the
//  display and cash-dispenser outputs.
// PARAMETERS
//  NUM_ACCOUNTS    4                          number of accounts; card_id values >= NUM_ACCOUNTS are invalid
//  PIN_W           16                         PIN width
//  AMT_W           14                         amount/balance width
//  PIN_TABLE       {16'h3333,16'h2222,16'h1111,16'h9284}  flat PINs; account k = bits [k*PIN_W +: PIN_W]
//  INIT_BALANCE    5000                       balance loaded into every account on rst
//  ATM_OUT_LIMIT   10000                      max single withdrawal
//  MAX_TRIES       3                          consecutive wrong PINs before lockout
//  TIMEOUT_CYCLES  1000                       idle cycles before abort
// PORTS
//  clk            in   1                  clock, all logic on posedge
//  rst            in   1                  synchronous, active-high reset
//  cancel         in   1                  user abort, synchronous, level-sensitive
//  next           in   1                  step button; acts on rising edge only
//  card_id        in   max(1,$clog2(NUM_ACCOUNTS))+1  card number; extra MSB lets invalid ids be tested
//  pin            in   PIN_W              entered PIN
//  cash_in        in   AMT_W              requested amount
//  success        out  1                  high only in S_DISPENSE
//  cash_out       out  AMT_W              latched amount in S_DISPENSE, else 0
//  state_display  out  3                  current state encoding
//  err_code       out  3                  0 none, 1 bad card, 2 locked, 3 wrong PIN, 4 bad amount, 5 funds, 6 timeout
//  balance_out    out  AMT_W              balance of the latched account in states 2-5, else 0
// BEHAVIOUR
//  Edge detect:
//   - nxt_edge = next & ~next_prev.
//   - next_prev <= next every cycle, including during cancel (no spurious edge after cancel). next_prev <= 0 on rst.
//  Priority per cycle: rst > cancel > timeout > nxt_edge.
//  rst:
//   - state=S_SCAN_CARD, all balances=INIT_BALANCE, all lock flags and try counters=0.
//   - err_code=0, latched card and amount=0.
//   - Outputs on the cycle after rst: success=0, cash_out=0, state_display=0, balance_out=0.
//  cancel: state <= S_SCAN_CARD and err_code <= 0. Balances, locks and try counters are unchanged.
//  States (state_display value):
//   - S_SCAN_CARD(0), on nxt_edge, latch card_id:
//       - id invalid -> S_REJECT, err=1.
//       - account locked -> S_REJECT, err=2.
//       - otherwise -> S_CHECK_PIN, err=0.
//   - S_CHECK_PIN(1), on nxt_edge:
//       - pin matches -> S_WITHDRAW_AMT, try counter of that account cleared, err=0.
//       - mismatch -> try counter +1 and err=3; if the counter reaches MAX_TRIES, set the lock flag -> S_REJECT, err=2; otherwise stay.
//   - S_WITHDRAW_AMT(2), on nxt_edge:
//       - cash_in==0 or cash_in>ATM_OUT_LIMIT -> stay, err=4.
//       - otherwise latch amount -> S_VERIFY_BALANCE, err=0.
//   - S_VERIFY_BALANCE(3): resolves after exactly 1 cycle, no next needed:
//       - amount<=balance -> balance -= amount (same edge) -> S_DISPENSE.
//       - otherwise -> S_REJECT, err=5.
//   - S_DISPENSE(4): success=1, cash_out=amount. On nxt_edge -> S_SCAN_CARD. A cancel here does not refund.
//   - S_REJECT(5): outputs idle, err_code held. On nxt_edge -> S_SCAN_CARD, err=0.
//   - Encodings 6 and 7 are unreachable -> S_SCAN_CARD on the next cycle.
//  Timeout:
//   - Idle counter is active in states 1, 2, 4, 5.
//   - Cleared on every state change and on every nxt_edge.
//   - When it reaches TIMEOUT_CYCLES: -> S_SCAN_CARD, err=6.
//  Arithmetic: the balance never underflows because of the VERIFY check. Comparisons are unsigned.
//  Lock flags persist across cancel and timeout; only rst clears them.
//  Outputs are derived from registered state only; there are no combinational paths from inputs to outputs.
// TESTING  (bench sets TIMEOUT_CYCLES=16)
//  1. Happy path: card 0, pin 9284, amount 1200 -> success=1, cash_out=1200, state 4; after next, balance_out on re-entry = 3800.
//  2. Lockout: card 1, three wrong PINs -> err 3,3 then state 5 with err 2; a new session on card 1 -> S_REJECT err=2, while card 2 still works.
//  3. Funds: card 0, amount 6000 -> state 3 for 1 cycle, then state 5 err=5, balance unchanged at 5000.
//  4. Limits: amount 0 and 10001 -> stay in state 2, err=4; amount 10000 on balance 5000 -> err=5.
//  5. Timeout and cancel:
//       - Idle 16 cycles in state 2 -> state 0, err=6.
//       - Cancel in state 4 with next held high -> state 0, no extra step on release or re-press, balance stays debited.
//  6. rst mid-session (state 2, balance 3800, card 1 locked) -> state 0, balances 5000, card 1 unlocked.

Source files
------------

// File: rtl/atm_multi_account.sv
// rtl/atm_multi_account.sv - multi-account ATM controller
// Per-account PIN, balance, wrong-PIN lockout, idle timeout and error reporting.
module atm_multi_account #(
  parameter int NUM_ACCOUNTS   = 4,
  parameter int PIN_W          = 16,
  parameter int AMT_W          = 14,
  parameter logic [NUM_ACCOUNTS*PIN_W-1:0] PIN_TABLE =
    {16'h3333, 16'h2222, 16'h1111, 16'h9284},
  parameter int INIT_BALANCE   = 5000,
  parameter int ATM_OUT_LIMIT  = 10000,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int AIDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1,
  localparam int CID_W  = AIDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cancel,
  input  logic             next,
  input  logic [CID_W-1:0] card_id,
  input  logic [PIN_W-1:0] pin,
  input  logic [AMT_W-1:0] cash_in,
  output logic             success,
  output logic [AMT_W-1:0] cash_out,
  output logic [2:0]       state_display,
  output logic [2:0]       err_code,
  output logic [AMT_W-1:0] balance_out
);

  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_SCAN_CARD      = 3'd0,
    S_CHECK_PIN      = 3'd1,
    S_WITHDRAW_AMT   = 3'd2,
    S_VERIFY_BALANCE = 3'd3,
    S_DISPENSE       = 3'd4,
    S_REJECT         = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               next_prev_q;
  logic [2:0]         err_q, err_d;
  logic [CID_W-1:0]   card_q, card_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic [AMT_W-1:0]   bal_q [NUM_ACCOUNTS];
  logic [AMT_W-1:0]   bal_d [NUM_ACCOUNTS];
  logic [TRY_W-1:0]   tries_q [NUM_ACCOUNTS];
  logic [TRY_W-1:0]   tries_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] locked_q, locked_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;

  logic               nxt_edge;
  logic               idle_active;
  logic               timeout;
  logic [IDLE_W-1:0]  idle_inc;
  logic [AIDX_W-1:0]  cidx;
  logic [AIDX_W-1:0]  scan_idx;
  logic [TRY_W-1:0]   tries_inc;
  logic               card_valid;

  assign nxt_edge    = next & ~next_prev_q;
  assign cidx        = card_q[AIDX_W-1:0];
  assign scan_idx    = card_id[AIDX_W-1:0];
  assign card_valid  = card_q < CID_W'(NUM_ACCOUNTS);
  assign idle_active = (state_q == S_CHECK_PIN) || (state_q == S_WITHDRAW_AMT) ||
                       (state_q == S_DISPENSE)  || (state_q == S_REJECT);
  assign idle_inc    = idle_active ? idle_q + 1'b1 : '0;
  assign timeout     = idle_active && (idle_inc == IDLE_W'(TIMEOUT_CYCLES));
  assign tries_inc   = tries_q[cidx] + 1'b1;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    card_d   = card_q;
    amt_d    = amt_q;
    bal_d    = bal_q;
    tries_d  = tries_q;
    locked_d = locked_q;

    if (cancel) begin
      state_d = S_SCAN_CARD;
      err_d   = 3'd0;
    end else if (timeout) begin
      state_d = S_SCAN_CARD;
      err_d   = 3'd6;
    end else begin
      case (state_q)
        S_SCAN_CARD: if (nxt_edge) begin
          card_d = card_id;
          if (card_id >= CID_W'(NUM_ACCOUNTS)) begin
            state_d = S_REJECT;
            err_d   = 3'd1;
          end else if (locked_q[scan_idx]) begin
            state_d = S_REJECT;
            err_d   = 3'd2;
          end else begin
            state_d = S_CHECK_PIN;
            err_d   = 3'd0;
          end
        end
        S_CHECK_PIN: if (nxt_edge) begin
          if (pin == PIN_TABLE[int'(cidx)*PIN_W +: PIN_W]) begin
            tries_d[cidx] = '0;
            state_d       = S_WITHDRAW_AMT;
            err_d         = 3'd0;
          end else begin
            tries_d[cidx] = tries_inc;
            if (tries_inc >= TRY_W'(MAX_TRIES)) begin
              locked_d[cidx] = 1'b1;
              state_d        = S_REJECT;
              err_d          = 3'd2;
            end else begin
              err_d = 3'd3;
            end
          end
        end
        S_WITHDRAW_AMT: if (nxt_edge) begin
          if (cash_in == '0 || cash_in > AMT_W'(ATM_OUT_LIMIT)) begin
            err_d = 3'd4;
          end else begin
            amt_d   = cash_in;
            state_d = S_VERIFY_BALANCE;
            err_d   = 3'd0;
          end
        end
        S_VERIFY_BALANCE: begin
          if (amt_q <= bal_q[cidx]) begin
            bal_d[cidx] = bal_q[cidx] - amt_q;
            state_d     = S_DISPENSE;
          end else begin
            state_d = S_REJECT;
            err_d   = 3'd5;
          end
        end
        S_DISPENSE: if (nxt_edge) state_d = S_SCAN_CARD;
        S_REJECT: if (nxt_edge) begin
          state_d = S_SCAN_CARD;
          err_d   = 3'd0;
        end
        default: state_d = S_SCAN_CARD;
      endcase
    end

    // The idle counter restarts on any state change or user step.
    idle_d = (state_d != state_q || nxt_edge) ? '0 : idle_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SCAN_CARD;
      next_prev_q <= 1'b0;
      err_q       <= 3'd0;
      card_q      <= '0;
      amt_q       <= '0;
      locked_q    <= '0;
      idle_q      <= '0;
      for (int k = 0; k < NUM_ACCOUNTS; k++) begin
        bal_q[k]   <= AMT_W'(INIT_BALANCE);
        tries_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      next_prev_q <= next;
      err_q       <= err_d;
      card_q      <= card_d;
      amt_q       <= amt_d;
      locked_q    <= locked_d;
      idle_q      <= idle_d;
      bal_q       <= bal_d;
      tries_q     <= tries_d;
    end
  end

  assign success       = (state_q == S_DISPENSE);
  assign cash_out      = success ? amt_q : '0;
  assign state_display = state_q;
  assign err_code      = err_q;
  assign balance_out   = (card_valid && state_q >= S_WITHDRAW_AMT && state_q <= S_REJECT)
                         ? bal_q[cidx] : '0;

endmodule
